bram_rd_stream: RTL and testbench
=================================

// Module: bram_rd_stream
// PURPOSE
//  Downstream of the BRAM address generator. Snoops its port-A strobes (ram_en/ram_we/read_over) and
//  samples BRAM read data at the fixed read latency. Buffers the words in a small FIFO and presents
//  them to the BP decode core as a valid/ready stream with an end-of-burst flag.
//  The address generator cannot stall, so FIFO overrun is flagged, never back-pressured.
// PARAMETERS
//  DATA_W      32  BRAM data width
//  RD_LAT      1   BRAM read latency in clocks (1..3); a read issued in cycle k returns data in cycle k+RD_LAT
//  FIFO_DEPTH  16  FIFO entries; power of two, >=4
// PORTS
//  clk          in   1        system clock, same clock as the BRAM port
//  rst_n        in   1        synchronous active-low reset
//  ram_en       in   1        BRAM enable from the address generator
//  ram_we       in   4        BRAM byte write enables from the address generator
//  read_over    in   1        one-cycle pulse, high the cycle after the last read of a burst is issued
//  ram_rd_data  in   DATA_W   BRAM read data
//  m_data       out  DATA_W   stream data (FIFO head)
//  m_valid      out  1        m_data valid
//  m_last       out  1        m_data is the final word of its burst
//  m_ready      in   1        consumer accepts; a beat transfers when m_valid & m_ready
//  fifo_level   out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  ovf_err      out  1        sticky: a returned word was dropped because the FIFO was full
//  err_clr      in   1        clears ovf_err
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): m_valid=0, m_last=0, m_data=0, fifo_level=0, ovf_err=0.
//    Tag pipeline and FIFO pointers are cleared. Reset mid-burst discards all in-flight and buffered words.
//  - Issue detect: rd_issue = ram_en & (ram_we==0), sampled each posedge.
//    Write cycles (any ram_we bit set) and idle cycles create no tag.
//  - Tag pipeline: RD_LAT stages, each holding {valid,last}. Stage 1 loads valid=rd_issue, last=0.
//    In stage 1, last is OR-ed with read_over, so the tag of the final issued read is marked last.
//    At stage RD_LAT, a valid tag pushes {ram_rd_data, last} into the FIFO on the same edge.
//  - FIFO: synchronous, first-word-fall-through. m_data/m_last/m_valid come straight from the FIFO head.
//    A word first becomes visible one cycle after it is pushed.
//    push = tag valid at stage RD_LAT; pop = m_valid & m_ready.
//    Full: a push with no simultaneous pop drops the word, sets ovf_err=1, and leaves fifo_level unchanged.
//    Full with a simultaneous pop: the push is accepted and fifo_level is unchanged.
//    Empty: m_valid=0; m_ready is ignored. Pointers wrap modulo FIFO_DEPTH.
//    fifo_level = pushes - pops, range 0..FIFO_DEPTH.
//  - ovf_err: set by a dropped push. Cleared by err_clr unless a drop occurs in the same cycle (set wins).
//  - m_data/m_last are stable while m_valid & ~m_ready.
//  - Latency: read issued in cycle k -> m_valid in cycle k+RD_LAT+1, provided the FIFO was empty.
//  - Throughput: one word per clock sustained when m_ready=1.
// CONFIGURATION
//  BRAM_RD_BYTESWAP_EN defined: the word pushed into the FIFO is byte-reversed
//    ({d[7:0],d[15:8],d[23:16],d[31:24]}); requires DATA_W=32.
//  BRAM_RD_BYTESWAP_EN undefined: ram_rd_data is stored unmodified. No other behaviour differs.
// TESTING
//  1. 4-word burst (ram_en=1, we=0 for 4 cycles, read_over the next cycle); data A0..A3; m_ready=1, RD_LAT=1
//     -> beats A0..A3 on consecutive cycles, first one 2 cycles after issue, m_last only on A3.
//  2. Write burst (we=4'hF, ram_en=1, 8 cycles) -> no push; fifo_level stays 0; m_valid stays 0.
//  3. m_ready=0, 20-word read burst, depth 16 -> fifo_level saturates at 16; words 17..20 dropped;
//     ovf_err=1. Then m_ready=1 -> 16 beats drain; no m_last (last word was dropped).
//  4. FIFO full with m_ready=1 in the same cycle as a new push -> no drop, fifo_level stays 16, ovf_err stays 0.
//  5. rst_n=0 for 1 cycle mid-burst with 5 words buffered -> next cycle m_valid=0, fifo_level=0, ovf_err=0;
//     later reads are captured normally.
//  6. RD_LAT=2, burst of 1 word 0x11223344 with BRAM_RD_BYTESWAP_EN defined
//     -> single beat 0x44332211 with m_last=1, 3 cycles after issue.

Source files
------------

// File: rtl/bram_rd_stream_if.sv
// =============================================================================
// bram_rd_stream_if : valid/ready stream carrying BRAM words with an end-of-burst flag.
// Rev 1.0
// =============================================================================
`default_nettype none

interface bram_rd_stream_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

`default_nettype wire

// File: rtl/bram_rd_stream.sv
// =============================================================================
// bram_rd_stream : snoops BRAM read strobes, captures data at RD_LAT, streams it out of a FWFT FIFO.
// Optional macro BRAM_RD_BYTESWAP_EN byte-reverses each stored word.  Rev 1.0
// =============================================================================
`default_nettype none

module bram_rd_stream #(
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  input  wire logic                          ram_en,
  input  wire logic [3:0]                    ram_we,
  input  wire logic                          read_over,
  input  wire logic [DATA_W-1:0]             ram_rd_data,
  bram_rd_stream_if.master                   m_if,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               ovf_err,
  input  wire logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [RD_LAT-1:0] tag_v_q, tag_v_d;
  logic [RD_LAT-1:0] tag_l_q, tag_l_d;
  logic [RD_LAT-1:0] tag_l_eff;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] mem_q      [FIFO_DEPTH];
  logic              mem_last_q [FIFO_DEPTH];

  logic              rd_issue;
  logic              push, push_last, push_ok, pop, drop, empty, full;
  logic [DATA_W-1:0] push_data;

  always_comb begin
    rd_issue = ram_en & (ram_we == 4'b0000);

    // read_over arrives one cycle after the final read, i.e. while its tag sits in stage 1
    tag_l_eff    = tag_l_q;
    tag_l_eff[0] = tag_l_q[0] | read_over;

    tag_v_d    = '0;
    tag_l_d    = '0;
    tag_v_d[0] = rd_issue;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_eff[i-1];
    end
  end

  always_comb begin
    push      = tag_v_q[RD_LAT-1];
    push_last = tag_l_eff[RD_LAT-1];
`ifdef BRAM_RD_BYTESWAP_EN
    push_data = {ram_rd_data[7:0], ram_rd_data[15:8], ram_rd_data[23:16], ram_rd_data[31:24]};
`else
    push_data = ram_rd_data;
`endif
  end

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == FULL_LVL);
    pop     = ~empty & m_if.m_ready;
    // the producer cannot stall, so a full FIFO without a pop loses the word
    drop    = push & full & ~pop;
    push_ok = push & ~drop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (err_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v_q  <= '0;
      tag_l_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      tag_v_q  <= tag_v_d;
      tag_l_q  <= tag_l_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // storage needs no reset: pointers and level define which entries are live
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q]      <= push_data;
      mem_last_q[wr_ptr_q] <= push_last;
    end
  end

  assign m_if.m_valid = ~empty;
  assign m_if.m_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign m_if.m_last  = ~empty & mem_last_q[rd_ptr_q];
  assign fifo_level   = level_q;
  assign ovf_err      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_rd_stream.sv
// =============================================================================
// tb_bram_rd_stream : drives two instances (RD_LAT=1 and RD_LAT=2) against a queue-level model.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_bram_rd_stream;

  localparam int DEPTH = 16;

`ifdef BRAM_RD_BYTESWAP_EN
  localparam logic [31:0] EXP_A0 = 32'h000000A0;
  localparam logic [31:0] EXP_A3 = 32'h030000A0;
  localparam logic [31:0] EXP_T6 = 32'h44332211;
`else
  localparam logic [31:0] EXP_A0 = 32'hA0000000;
  localparam logic [31:0] EXP_A3 = 32'hA0000003;
  localparam logic [31:0] EXP_T6 = 32'h11223344;
`endif

  logic        clk;
  logic        rst_n;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic        read_over;
  logic [7:0]  addr;
  logic        err_clr;
  logic        ready;
  logic [31:0] p0, p1;
  logic [31:0] mem [256];
  logic [4:0]  lvl1, lvl2;
  logic        ovf1, ovf2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit started  = 0;

  bram_rd_stream_if #(.DATA_W(32)) s1 ();
  bram_rd_stream_if #(.DATA_W(32)) s2 ();
  assign s1.m_ready = ready;
  assign s2.m_ready = ready;

  bram_rd_stream #(.DATA_W(32), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_we(ram_we), .read_over(read_over),
    .ram_rd_data(p0), .m_if(s1), .fifo_level(lvl1), .ovf_err(ovf1), .err_clr(err_clr));

  bram_rd_stream #(.DATA_W(32), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) u2 (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_we(ram_we), .read_over(read_over),
    .ram_rd_data(p1), .m_if(s2), .fifo_level(lvl2), .ovf_err(ovf2), .err_clr(err_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM with a one- or two-stage registered read
  always @(posedge clk) begin
    p0 <= mem[addr];
    p1 <= p0;
  end

  function automatic logic [31:0] sw(input logic [31:0] d);
`ifdef BRAM_RD_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // model state, index 0 -> u1, index 1 -> u2
  logic [31:0] fq_data [2][DEPTH];
  bit          fq_last [2][DEPTH];
  int          fq_head [2];
  int          fq_size [2];
  bit          m_ovf   [2];
  int          pend_cyc  [2][8];
  logic [31:0] pend_data [2][8];
  bit          pend_last [2][8];
  int          pend_n    [2];

  task automatic model_step(input int d, input int lat);
    if (!rst_n) begin
      fq_head[d] = 0; fq_size[d] = 0; m_ovf[d] = 0; pend_n[d] = 0;
      return;
    end
    if (read_over && pend_n[d] > 0 && pend_cyc[d][pend_n[d]-1] == cyc - 1)
      pend_last[d][pend_n[d]-1] = 1;
    if (fq_size[d] > 0 && ready) begin
      fq_head[d] = (fq_head[d] + 1) % DEPTH;
      fq_size[d] = fq_size[d] - 1;
    end
    if (pend_n[d] > 0 && pend_cyc[d][0] + lat == cyc) begin
      if (fq_size[d] == DEPTH) begin
        m_ovf[d] = 1;
      end else begin
        fq_data[d][(fq_head[d] + fq_size[d]) % DEPTH] = pend_data[d][0];
        fq_last[d][(fq_head[d] + fq_size[d]) % DEPTH] = pend_last[d][0];
        fq_size[d] = fq_size[d] + 1;
        if (err_clr) m_ovf[d] = 0;
      end
      for (int i = 1; i < pend_n[d]; i++) begin
        pend_cyc[d][i-1]  = pend_cyc[d][i];
        pend_data[d][i-1] = pend_data[d][i];
        pend_last[d][i-1] = pend_last[d][i];
      end
      pend_n[d] = pend_n[d] - 1;
    end else if (err_clr) begin
      m_ovf[d] = 0;
    end
    if (ram_en && ram_we == 4'b0000) begin
      pend_cyc[d][pend_n[d]]  = cyc;
      pend_data[d][pend_n[d]] = sw(mem[addr]);
      pend_last[d][pend_n[d]] = 0;
      pend_n[d] = pend_n[d] + 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 1);
    model_step(1, 2);
    started = 1;
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp(input int d, input logic v, input logic [31:0] dat, input logic lst,
                     input logic [4:0] lvl, input logic ovf);
    logic ev;
    ev = (fq_size[d] > 0);
    chk($sformatf("m_valid%0d", d), {31'b0, v}, {31'b0, ev});
    if (ev) begin
      chk($sformatf("m_data%0d", d), dat, fq_data[d][fq_head[d]]);
      chk($sformatf("m_last%0d", d), {31'b0, lst}, {31'b0, fq_last[d][fq_head[d]]});
    end
    chk($sformatf("fifo_level%0d", d), {27'b0, lvl}, 32'(fq_size[d]));
    chk($sformatf("ovf_err%0d", d), {31'b0, ovf}, {31'b0, m_ovf[d]});
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp(0, s1.m_valid, s1.m_data, s1.m_last, lvl1, ovf1);
      cmp(1, s2.m_valid, s2.m_data, s2.m_last, lvl2, ovf2);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [7:0] a);
    ram_en = 1'b1; ram_we = 4'h0; addr = a;
    step();
  endtask

  task automatic rd_over();
    ram_en = 1'b0; read_over = 1'b1;
    step();
    read_over = 1'b0;
  endtask

  task automatic idle(input int n);
    ram_en = 1'b0; ram_we = 4'h0;
    repeat (n) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA0000000 | 32'(i);
    mem[8'h40] = 32'h11223344;
    rst_n = 1'b0; ram_en = 1'b0; ram_we = 4'h0; read_over = 1'b0;
    addr = 8'h00; err_clr = 1'b0; ready = 1'b0;

    // reset state
    step(); step(); #3;
    chk("rst_m_valid", {31'b0, s1.m_valid}, 32'd0);
    chk("rst_m_data",  s1.m_data, 32'd0);
    chk("rst_m_last",  {31'b0, s1.m_last}, 32'd0);
    chk("rst_level",   {27'b0, lvl1}, 32'd0);
    chk("rst_ovf",     {31'b0, ovf1}, 32'd0);
    rst_n = 1'b1;
    step();

    // 4-word burst, RD_LAT=1 first beat two cycles after issue
    ready = 1'b1;
    rd(8'd0); #3;
    chk("t1_not_yet", {31'b0, s1.m_valid}, 32'd0);
    rd(8'd1); #3;
    chk("t1_first_valid", {31'b0, s1.m_valid}, 32'd1);
    chk("t1_first_data",  s1.m_data, EXP_A0);
    chk("t1_first_last",  {31'b0, s1.m_last}, 32'd0);
    rd(8'd2);
    rd(8'd3);
    rd_over(); #3;
    chk("t1_last_data", s1.m_data, EXP_A3);
    chk("t1_last_flag", {31'b0, s1.m_last}, 32'd1);
    idle(4);

    // write burst creates no words
    ram_en = 1'b1; ram_we = 4'hF;
    for (int i = 0; i < 8; i++) begin addr = 8'(i); step(); end
    idle(3); #3;
    chk("t2_level", {27'b0, lvl1}, 32'd0);
    chk("t2_valid", {31'b0, s1.m_valid}, 32'd0);

    // overflow: 20 words into a 16-deep FIFO with no consumer
    ready = 1'b0;
    for (int i = 0; i < 20; i++) rd(8'(16 + i));
    rd_over();
    idle(3); #3;
    chk("t3_level1", {27'b0, lvl1}, 32'd16);
    chk("t3_ovf1",   {31'b0, ovf1}, 32'd1);
    chk("t3_level2", {27'b0, lvl2}, 32'd16);
    chk("t3_ovf2",   {31'b0, ovf2}, 32'd1);
    ready = 1'b1;
    idle(18); #3;
    chk("t3_drained", {27'b0, lvl1}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; #3;
    chk("t3_ovf_clr", {31'b0, ovf1}, 32'd0);

    // full FIFO, push coincides with a pop on u1
    ready = 1'b0;
    for (int i = 0; i < 16; i++) rd(8'(48 + i));
    rd_over();
    idle(3);
    rd(8'd100);
    ram_en = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    step(); #3;
    chk("t4_level", {27'b0, lvl1}, 32'd16);
    chk("t4_ovf",   {31'b0, ovf1}, 32'd0);
    ready = 1'b1;
    idle(20);

    // reset mid-burst with buffered words
    ready = 1'b0;
    for (int i = 0; i < 6; i++) rd(8'(60 + i));
    rst_n = 1'b0;
    rd(8'd66);
    rst_n = 1'b1; #3;
    chk("t5_valid", {31'b0, s1.m_valid}, 32'd0);
    chk("t5_level", {27'b0, lvl1}, 32'd0);
    chk("t5_ovf",   {31'b0, ovf1}, 32'd0);
    ready = 1'b1;
    rd(8'd67);
    rd(8'd68);
    rd_over();
    idle(5);

    // single word on the RD_LAT=2 instance, visible three cycles after issue
    rd(8'h40);
    rd_over(); #3;
    chk("t6_not_yet", {31'b0, s2.m_valid}, 32'd0);
    step(); #3;
    chk("t6_valid", {31'b0, s2.m_valid}, 32'd1);
    chk("t6_data",  s2.m_data, EXP_T6);
    chk("t6_last",  {31'b0, s2.m_last}, 32'd1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
